burst_master_port: RTL and testbench
====================================

BURST_MASTER_PORT -- requirements
Module: burst_master_port

Interface
REQ-001 AW, 32, address width.
REQ-002 DW, 32, data width; BEW=DW/8 byte enables.
REQ-003 BCW, 4, burstcount width; max burst 2^BCW-1.
REQ-004 WFIFO_DEPTH, 8, write-data buffer depth, power of 2, >=2.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 cmd_valid  in  1  CPU command request.
REQ-008 cmd_ready  out  1  port accepts command.
REQ-009 cmd_write  in  1  1=write burst, 0=read burst.
REQ-010 cmd_addr  in  AW  burst start address.
REQ-011 cmd_be  in  BEW  byte enables for every beat.
REQ-012 cmd_burst  in  BCW  beat count.
REQ-013 wr_valid  in  1  CPU write-data beat valid.
REQ-014 wr_ready  out  1  write buffer not full.
REQ-015 wr_data  in  DW  write-data beat.
REQ-016 rd_valid  out  1  read beat valid (1-cycle pulse per beat).
REQ-017 rd_data  out  DW  read beat data.
REQ-018 rd_last  out  1  final read beat marker.
REQ-019 done  out  1  transaction complete, 1-cycle pulse.
REQ-020 err  out  1  protocol/command error, 1-cycle pulse.
REQ-021 m_read  out  1  bus read request.
REQ-022 m_write  out  1  bus write request.
REQ-023 m_addr  out  AW  bus address.
REQ-024 m_be  out  BEW  bus byte enables.
REQ-025 m_burst  out  BCW  bus burstcount.
REQ-026 m_wdata  out  DW  bus write data.
REQ-027 m_waitrequest  in  1  slave stall.
REQ-028 m_rvalid  in  1  slave read data valid.
REQ-029 m_rdata  in  DW  slave read data.

Function
REQ-030 FSM states IDLE, RD_REQ, RD_DATA, WR_REQ, DONE; cmd_ready=1 only in IDLE; command accepted on cmd_valid&cmd_ready.
REQ-031 Accepted command with cmd_burst=0: no bus activity, err=1 next cycle, FSM stays IDLE.
REQ-032 Read accept: next cycle m_read=1, m_addr/m_be/m_burst hold latched values, beat counter=cmd_burst, state RD_REQ.
REQ-033 RD_REQ: m_read held until a cycle with m_waitrequest=0; m_read=0 on the following cycle; state RD_DATA.
REQ-034 m_rvalid is counted in RD_REQ (from the cycle after acceptance) and in RD_DATA. Per beat: rd_valid=1 and rd_data=m_rdata one cycle later; counter decrements; rd_last=1 with the final beat.
REQ-035 Final read or write beat: next state DONE; done=1 for one cycle; then IDLE.
REQ-036 Write buffer: push on wr_valid&wr_ready in any state; wr_ready=~full. Prefill before the command is allowed. A pop in the same cycle does not lift wr_ready when full.
REQ-037 Write accept: state WR_REQ; counter=cmd_burst; m_addr/m_be/m_burst constant for the whole burst.
REQ-038 WR_REQ: m_write=1 iff buffer non-empty; m_wdata=buffer head. A beat transfers on m_write&~m_waitrequest, which pops and decrements. An empty buffer drops m_write (gap) without abort.
REQ-039 While m_waitrequest=1 with m_read or m_write asserted, all m_* outputs hold unchanged.
REQ-040 m_rvalid in IDLE, WR_REQ or DONE is ignored for data and pulses err.
REQ-041 Counter and FIFO pointers wrap modulo their widths. A full FIFO with count=WFIFO_DEPTH is distinct from empty.

Reset
REQ-042 rst=0 at a clock edge gives: state IDLE, all outputs 0, FIFO empty, counter 0. A mid-burst transaction is abandoned with no done and no err.

Structure
REQ-043 Shared package port_pkg holds the FSM state enum and the default AW/DW/BCW constants.
REQ-044 The write buffer is sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty).

Verification
REQ-045 Read, addr=0x100, burst=4, waitrequest=1 for 2 cycles, rvalid data 0xA0..0xA3 -> m_read high exactly 3 cycles; 4 rd_valid; rd_last on 0xA3; single done.
REQ-046 Prefill 3 beats, then write, burst=3, waitrequest toggling -> m_wdata order preserved and stable during stalls; done after 3rd beat.
REQ-047 Write, burst=4, data pushed 1 beat per 3 cycles -> m_write gaps, 4 transfers, no err.
REQ-048 cmd_burst=0 -> err pulse, no m_read/m_write, cmd_ready stays 1.
REQ-049 Push 9 beats with no pop, DEPTH=8 -> wr_ready=0 after 8; 9th not stored.
REQ-050 rst=0 mid read burst (beat 2 of 4) -> next cycle all outputs 0, IDLE; a following read completes normally.

Source files
------------

// File: rtl/port_pkg.sv
// Shared constants for the burst master port: default widths and FSM state encodings.
package port_pkg;

  localparam int unsigned DefaultAw         = 32;
  localparam int unsigned DefaultDw         = 32;
  localparam int unsigned DefaultBcw        = 4;
  localparam int unsigned DefaultWfifoDepth = 8;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdReq  = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy count so full and empty stay distinct.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/burst_master_port.sv
// CPU-side command/data port driving an Avalon-style burst master, with a buffered write path.
module burst_master_port
  import port_pkg::*;
#(
  parameter int unsigned AW          = DefaultAw,
  parameter int unsigned DW          = DefaultDw,
  parameter int unsigned BCW         = DefaultBcw,
  parameter int unsigned WFIFO_DEPTH = DefaultWfifoDepth
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW/8-1:0] cmd_be,
  input  logic [BCW-1:0]  cmd_burst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            done,
  output logic            err,
  output logic            m_read,
  output logic            m_write,
  output logic [AW-1:0]   m_addr,
  output logic [DW/8-1:0] m_be,
  output logic [BCW-1:0]  m_burst,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_waitrequest,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  logic [2:0]      state_q, state_d;
  logic [BCW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW/8-1:0] be_q, be_d;
  logic [BCW-1:0]  burst_q, burst_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            m_read_q, m_read_d;
  logic            rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic            done_q, done_d, err_q, err_d;
  logic            init_q;
  logic            fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_head;
  logic            accept, rd_phase, rd_beat, wr_xfer;

  // init_q keeps the ready outputs low during the reset cycle itself.
  assign cmd_ready = init_q & (state_q == StIdle);
  assign wr_ready  = init_q & ~fifo_full;
  assign accept    = cmd_valid & cmd_ready;
  assign m_write   = (state_q == StWrReq) & ~fifo_empty;
  assign m_wdata   = m_write ? fifo_head : '0;
  assign wr_xfer   = m_write & ~m_waitrequest;
  assign rd_phase  = (state_q == StRdReq) | (state_q == StRdData);
  assign rd_beat   = m_rvalid & rd_phase;

  assign m_read   = m_read_q;
  assign m_addr   = addr_q;
  assign m_be     = be_q;
  assign m_burst  = burst_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;
  assign err      = err_q;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid & wr_ready),
    .wdata (wr_data),
    .pop   (wr_xfer),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    burst_d    = burst_q;
    m_read_d   = m_read_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;
    // Stray read data outside a read burst is dropped and flagged.
    err_d      = m_rvalid & ~rd_phase;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cmd_burst == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            be_d    = cmd_be;
            burst_d = cmd_burst;
            cnt_d   = cmd_burst;
            if (cmd_write) begin
              state_d = StWrReq;
            end else begin
              state_d  = StRdReq;
              m_read_d = 1'b1;
            end
          end
        end
      end
      StRdReq: begin
        if (!m_waitrequest) begin
          m_read_d = 1'b0;
          state_d  = StRdData;
        end
      end
      StRdData: ;
      StWrReq: begin
        if (wr_xfer) begin
          cnt_d = cnt_q - BCW'(1);
          if (cnt_q == BCW'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (rd_beat) begin
      rd_valid_d = 1'b1;
      rd_data_d  = m_rdata;
      cnt_d      = cnt_q - BCW'(1);
      if (cnt_q == BCW'(1)) begin
        rd_last_d = 1'b1;
        m_read_d  = 1'b0;
        state_d   = StDone;
      end
    end

    done_d = (state_d == StDone) & (state_q != StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      burst_q    <= '0;
      rd_data_q  <= '0;
      m_read_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      burst_q    <= burst_d;
      rd_data_q  <= rd_data_d;
      m_read_q   <= m_read_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
      init_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// Directed bench for burst_master_port: a cycle table for reads/errors plus hand sequences.
module tb_burst_master_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [3:0]  cmd_burst;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_last, done, err;
  logic [31:0] rd_data;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be, m_burst;
  logic        m_waitrequest, m_rvalid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_master_port dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_be        (cmd_be),
    .cmd_burst     (cmd_burst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .done          (done),
    .err           (err),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_addr        (m_addr),
    .m_be          (m_be),
    .m_burst       (m_burst),
    .m_wdata       (m_wdata),
    .m_waitrequest (m_waitrequest),
    .m_rvalid      (m_rvalid),
    .m_rdata       (m_rdata)
  );

  typedef struct {
    logic        cv;
    logic [31:0] addr;
    logic [3:0]  burst;
    logic        wreq;
    logic        rv;
    logic [31:0] rdat;
    logic        e_mread;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_last;
    logic        e_done;
    logic        e_err;
    logic        e_cready;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, " wr_ready"}, 64'(wr_ready), 64'd0);
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, " rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, " rd_last"}, 64'(rd_last), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " m_read"}, 64'(m_read), 64'd0);
    chk({tag, " m_write"}, 64'(m_write), 64'd0);
    chk({tag, " m_addr"}, 64'(m_addr), 64'd0);
    chk({tag, " m_be"}, 64'(m_be), 64'd0);
    chk({tag, " m_burst"}, 64'(m_burst), 64'd0);
    chk({tag, " m_wdata"}, 64'(m_wdata), 64'd0);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] burst);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_burst = burst;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int xfers;
    int gaps;
    int errs;
    int pushed;
    logic done_seen;
    logic [7:0] wpat;

    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = 4'hF;
    cmd_burst = '0; wr_valid = 1'b0; wr_data = '0; m_waitrequest = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0;

    // Read burst with two stall cycles, then zero-burst and stray-rvalid errors.
    vecs[0]  = '{1'b1, 32'h100, 4'd4, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[1]  = '{1'b0, 32'h0,   4'd0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[2]  = '{1'b0, 32'h0,   4'd0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[3]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[4]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[5]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[6]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[7]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100};
    vecs[8]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100};
    vecs[9]  = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[10] = '{1'b1, 32'h200, 4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100};
    vecs[11] = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[12] = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100};
    vecs[13] = '{1'b0, 32'h0,   4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100};

    step();
    step();
    chk_outputs_zero("reset");
    rst = 1'b1;
    step();
    chk("post-reset cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post-reset wr_ready", 64'(wr_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      cmd_valid     = vecs[i].cv;
      cmd_write     = 1'b0;
      cmd_addr      = vecs[i].addr;
      cmd_burst     = vecs[i].burst;
      m_waitrequest = vecs[i].wreq;
      m_rvalid      = vecs[i].rv;
      m_rdata       = vecs[i].rdat;
      step();
      chk($sformatf("vec%0d m_read", i), 64'(m_read), 64'(vecs[i].e_mread));
      chk($sformatf("vec%0d m_write", i), 64'(m_write), 64'd0);
      chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].e_rvalid));
      chk($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(vecs[i].e_rdata));
      chk($sformatf("vec%0d rd_last", i), 64'(rd_last), 64'(vecs[i].e_last));
      chk($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].e_done));
      chk($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].e_err));
      chk($sformatf("vec%0d cmd_ready", i), 64'(cmd_ready), 64'(vecs[i].e_cready));
      chk($sformatf("vec%0d m_addr", i), 64'(m_addr), 64'(vecs[i].e_maddr));
    end
    cmd_valid = 1'b0; m_rvalid = 1'b0; m_waitrequest = 1'b0;

    // Prefilled write burst of 3 under a toggling stall pattern.
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hB0 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    m_waitrequest = 1'b1;
    issue(1'b1, 32'h300, 4'd3);
    wpat = 8'b0010_1101;
    idx = 0;
    for (int c = 0; c < 8 && idx < 3; c++) begin
      m_waitrequest = wpat[c];
      chk("wr3 m_write", 64'(m_write), 64'd1);
      chk("wr3 m_wdata", 64'(m_wdata), 64'(32'hB0 + 32'(idx)));
      chk("wr3 m_addr", 64'(m_addr), 64'h300);
      chk("wr3 m_burst", 64'(m_burst), 64'd3);
      step();
      if (!wpat[c]) idx++;
    end
    chk("wr3 beats", 64'(idx), 64'd3);
    chk("wr3 done", 64'(done), 64'd1);
    chk("wr3 m_write after", 64'(m_write), 64'd0);
    m_waitrequest = 1'b0;
    step();
    chk("wr3 done pulse", 64'(done), 64'd0);
    chk("wr3 cmd_ready", 64'(cmd_ready), 64'd1);

    // Write burst of 4 with data trickling in one beat per 3 cycles.
    issue(1'b1, 32'h340, 4'd4);
    xfers = 0; gaps = 0; errs = 0; pushed = 0; done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      wr_valid = (c % 3 == 0) && (pushed < 4);
      wr_data  = 32'hC0 + 32'(pushed);
      if (m_write) begin
        chk("trickle m_wdata", 64'(m_wdata), 64'(32'hC0 + 32'(xfers)));
        xfers++;
      end else begin
        gaps++;
      end
      if (err) errs++;
      step();
      if (wr_valid) pushed++;
      if (done) done_seen = 1'b1;
    end
    wr_valid = 1'b0;
    chk("trickle done", 64'(done_seen), 64'd1);
    chk("trickle xfers", 64'(xfers), 64'd4);
    chk("trickle gaps seen", 64'(gaps > 1), 64'd1);
    chk("trickle errs", 64'(errs), 64'd0);
    step();

    // Overfill: 9 pushes into an 8-deep buffer.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("fill%0d wr_ready", i), 64'(wr_ready), 64'(i < 8));
      wr_valid = 1'b1;
      wr_data  = 32'hD0 + 32'(i);
      step();
    end
    wr_valid = 1'b0;
    chk("full wr_ready", 64'(wr_ready), 64'd0);
    issue(1'b1, 32'h380, 4'd8);
    for (int k = 0; k < 8; k++) begin
      chk("drain m_write", 64'(m_write), 64'd1);
      chk("drain m_wdata", 64'(m_wdata), 64'(32'hD0 + 32'(k)));
      step();
    end
    chk("drain done", 64'(done), 64'd1);
    chk("drain wr_ready", 64'(wr_ready), 64'd1);
    step();
    issue(1'b1, 32'h3C0, 4'd1);
    chk("empty m_write", 64'(m_write), 64'd0);
    step();
    chk("empty m_write 2", 64'(m_write), 64'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hE0;
    step();
    wr_valid = 1'b0;
    chk("after-full m_write", 64'(m_write), 64'd1);
    chk("after-full m_wdata", 64'(m_wdata), 64'hE0);
    step();
    chk("after-full done", 64'(done), 64'd1);
    step();

    // Reset during beat 2 of a 4-beat read, then a clean 2-beat read.
    issue(1'b0, 32'h400, 4'd4);
    chk("rst-rd m_read", 64'(m_read), 64'd1);
    step();
    chk("rst-rd m_read drop", 64'(m_read), 64'd0);
    m_rvalid = 1'b1; m_rdata = 32'hF0;
    step();
    chk("rst-rd beat1", 64'(rd_data), 64'hF0);
    m_rdata = 32'hF1;
    rst = 1'b0;
    step();
    chk_outputs_zero("midreset");
    rst = 1'b1;
    m_rvalid = 1'b0;
    step();
    chk("rerun cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rerun done", 64'(done), 64'd0);
    chk("rerun err", 64'(err), 64'd0);
    issue(1'b0, 32'h500, 4'd2);
    chk("rerun m_read", 64'(m_read), 64'd1);
    chk("rerun m_addr", 64'(m_addr), 64'h500);
    chk("rerun m_burst", 64'(m_burst), 64'd2);
    chk("rerun m_be", 64'(m_be), 64'hF);
    step();
    m_rvalid = 1'b1; m_rdata = 32'h61;
    step();
    chk("rerun beat1", 64'({rd_valid, rd_last, rd_data}), 64'({1'b1, 1'b0, 32'h61}));
    m_rdata = 32'h62;
    step();
    chk("rerun beat2", 64'({rd_valid, rd_last, rd_data}), 64'({1'b1, 1'b1, 32'h62}));
    chk("rerun done pulse", 64'(done), 64'd1);
    m_rvalid = 1'b0;
    step();
    chk("rerun done clear", 64'(done), 64'd0);
    chk("rerun idle", 64'(cmd_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
